// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN majority-vote classifier.
// Holds default sizes, the FSM state encoding and width helpers.
package knn_vote_pkg;

    localparam int LABEL_DEF       = 8;
    localparam int N_NEIGHBOUR_DEF = 10;
    localparam int N_CLASSES_DEF   = 16;
    localparam int CNT_W_DEF       = $clog2(N_NEIGHBOUR_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int cls_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/knn_vote_if.sv
// Request/result bundle of the KNN majority-vote classifier.
// master: start, neighbour_info, k_used out; busy, done, label_out,
// vote_cnt, no_vote in. slave: the reverse (the classifier side).
interface knn_vote_if #(
    parameter int LABEL       = knn_vote_pkg::LABEL_DEF,
    parameter int N_NEIGHBOUR = knn_vote_pkg::N_NEIGHBOUR_DEF,
    parameter int N_CLASSES   = knn_vote_pkg::N_CLASSES_DEF
);

    localparam int CNT_W = $clog2(N_NEIGHBOUR + 1);

    logic                         start;
    logic [LABEL*N_NEIGHBOUR-1:0] neighbour_info;
    logic [CNT_W-1:0]             k_used;
    logic                         busy;
    logic                         done;
    logic [LABEL-1:0]             label_out;
    logic [CNT_W-1:0]             vote_cnt;
    logic                         no_vote;

    modport master (
        output start, neighbour_info, k_used,
        input  busy, done, label_out, vote_cnt, no_vote
    );

    modport slave (
        input  start, neighbour_info, k_used,
        output busy, done, label_out, vote_cnt, no_vote
    );

endinterface

// File: rtl/knn_vote_hist.sv
// Per-class vote counter bank for knn_vote (N_CLASSES entries).
// Ports: clk, rst, clr, inc, inc_idx, rd_idx, rd_cnt; with
// KNN_VOTE_TIE_NEAREST_EN also inc_slot, rd_first (first slot per class).
module knn_vote_hist
    import knn_vote_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int CLS_W     = cls_w(N_CLASSES_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CLS_W-1:0] inc_idx,
`ifdef KNN_VOTE_TIE_NEAREST_EN
    input  logic [CNT_W-1:0] inc_slot,
    output logic [CNT_W-1:0] rd_first,
`endif
    input  logic [CLS_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);

    logic [CNT_W-1:0] cnt_q [N_CLASSES];
    logic [CNT_W-1:0] cnt_d [N_CLASSES];

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt_d[c] = '0;
            end
        end else if (inc) begin
            cnt_d[inc_idx] = cnt_q[inc_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt = cnt_q[rd_idx];

`ifdef KNN_VOTE_TIE_NEAREST_EN
    logic [CNT_W-1:0] first_q [N_CLASSES];
    logic [CNT_W-1:0] first_d [N_CLASSES];

    // Slots arrive nearest-first, so the slot seen while the count is
    // still zero is the nearest occurrence of that class.
    always_comb begin
        first_d = first_q;
        if (clr) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                first_d[c] = '0;
            end
        end else if (inc && (cnt_q[inc_idx] == '0)) begin
            first_d[inc_idx] = inc_slot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                first_q[c] <= '0;
            end
        end else begin
            first_q <= first_d;
        end
    end

    assign rd_first = first_q[rd_idx];
`endif

endmodule

// File: rtl/knn_vote.sv
// Majority-vote classifier over the K-nearest label list (top level).
// Ports: clk, rst (sync, active-high), bus (knn_vote_if.slave).
// Build option KNN_VOTE_TIE_NEAREST_EN: ties go to the nearest class.
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int LABEL       = LABEL_DEF,
    parameter int N_NEIGHBOUR = N_NEIGHBOUR_DEF,
    parameter int N_CLASSES   = N_CLASSES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    knn_vote_if.slave  bus
);

    localparam int CNT_W  = $clog2(N_NEIGHBOUR + 1);
    localparam int CLS_W  = cls_w(N_CLASSES);
    localparam int SNAP_W = LABEL * N_NEIGHBOUR;

    state_e             state_q, state_d;
    logic [SNAP_W-1:0]  snap_q, snap_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CLS_W-1:0]   cls_q, cls_d;
    logic [CLS_W-1:0]   best_cls_q, best_cls_d;
    logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;
    logic [LABEL-1:0]   label_q, label_d;
    logic [CNT_W-1:0]   vote_q, vote_d;
    logic               no_vote_q, no_vote_d;
    logic               done_q, done_d;

    logic               hist_clr;
    logic               hist_inc;
    logic [CNT_W-1:0]   hist_cnt;
    logic [CNT_W-1:0]   k_in;
    logic [LABEL-1:0]   cur_lab;
    logic               in_range;
    logic               take;

    assign k_in = (bus.k_used > CNT_W'(N_NEIGHBOUR))
                ? CNT_W'(N_NEIGHBOUR) : bus.k_used;

    // The snapshot shifts down one slot per COUNT cycle, so the
    // current slot is always in the low bits.
    assign cur_lab  = snap_q[LABEL-1:0];
    assign in_range = {1'b0, cur_lab} < (LABEL+1)'(N_CLASSES);

`ifdef KNN_VOTE_TIE_NEAREST_EN
    logic [CNT_W-1:0] hist_first;
    logic [CNT_W-1:0] best_first_q, best_first_d;

    assign take = (hist_cnt > best_cnt_q)
               || ((hist_cnt == best_cnt_q) && (hist_cnt != '0)
                   && (hist_first < best_first_q));
`else
    // Strict compare: on a tie the earlier (smaller) class stays.
    assign take = hist_cnt > best_cnt_q;
`endif

    knn_vote_hist #(
        .N_CLASSES (N_CLASSES),
        .CNT_W     (CNT_W),
        .CLS_W     (CLS_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (hist_clr),
        .inc      (hist_inc),
        .inc_idx  (CLS_W'(cur_lab)),
`ifdef KNN_VOTE_TIE_NEAREST_EN
        .inc_slot (idx_q),
        .rd_first (hist_first),
`endif
        .rd_idx   (cls_q),
        .rd_cnt   (hist_cnt)
    );

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        k_d        = k_q;
        idx_d      = idx_q;
        cls_d      = cls_q;
        best_cls_d = best_cls_q;
        best_cnt_d = best_cnt_q;
        label_d    = label_q;
        vote_d     = vote_q;
        no_vote_d  = no_vote_q;
        done_d     = 1'b0;
        hist_clr   = 1'b0;
        hist_inc   = 1'b0;
`ifdef KNN_VOTE_TIE_NEAREST_EN
        best_first_d = best_first_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    snap_d     = bus.neighbour_info;
                    k_d        = k_in;
                    idx_d      = '0;
                    cls_d      = '0;
                    best_cls_d = '0;
                    best_cnt_d = '0;
                    hist_clr   = 1'b1;
`ifdef KNN_VOTE_TIE_NEAREST_EN
                    best_first_d = '0;
`endif
                    state_d = (k_in == '0) ? ST_SCAN : ST_COUNT;
                end
            end
            ST_COUNT: begin
                hist_inc = in_range;
                snap_d   = snap_q >> LABEL;
                idx_d    = idx_q + 1'b1;
                if (idx_q == k_q - 1'b1) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (take) begin
                    best_cls_d = cls_q;
                    best_cnt_d = hist_cnt;
`ifdef KNN_VOTE_TIE_NEAREST_EN
                    best_first_d = hist_first;
`endif
                end
                cls_d = cls_q + 1'b1;
                if (cls_q == CLS_W'(N_CLASSES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                vote_d    = best_cnt_q;
                no_vote_d = (best_cnt_q == '0);
                label_d   = (best_cnt_q == '0)
                          ? '0 : LABEL'(best_cls_q);
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            k_q        <= '0;
            idx_q      <= '0;
            cls_q      <= '0;
            best_cls_q <= '0;
            best_cnt_q <= '0;
            label_q    <= '0;
            vote_q     <= '0;
            no_vote_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            cls_q      <= cls_d;
            best_cls_q <= best_cls_d;
            best_cnt_q <= best_cnt_d;
            label_q    <= label_d;
            vote_q     <= vote_d;
            no_vote_q  <= no_vote_d;
            done_q     <= done_d;
        end
    end

`ifdef KNN_VOTE_TIE_NEAREST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            best_first_q <= '0;
        end else begin
            best_first_q <= best_first_d;
        end
    end
`endif

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.label_out = label_q;
    assign bus.vote_cnt  = vote_q;
    assign bus.no_vote   = no_vote_q;

endmodule
